// File: rtl/seq_mul_pkg.sv
// rtl/seq_mul_pkg.sv - shared types and helpers for the sequential shift-add multiplier
package seq_mul_pkg;

    localparam int MAX_W = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Negates v when neg is set; callers size-cast the result to their operand width.
    function automatic logic [MAX_W-1:0] abs_val(input logic [MAX_W-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    function automatic int cnt_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/seq_mul_dp.sv
// rtl/seq_mul_dp.sv - operand, accumulator and counter registers with the add/shift step
module seq_mul_dp
    import seq_mul_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               step,
    input  logic               finish,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               sgn,
    output logic               last,
    output logic [2*WIDTH-1:0] s
);

    localparam int CW = cnt_width(WIDTH);

    logic [2*WIDTH-1:0] ma_ext;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   mb;
    logic [CW-1:0]      cnt;
    logic               neg;

    logic [WIDTH-1:0]   ma_mag;
    logic [WIDTH-1:0]   mb_mag;

    // The most negative input maps to 2^(WIDTH-1), which still fits unsigned.
    assign ma_mag = WIDTH'(abs_val(MAX_W'(a), sgn & a[WIDTH-1]));
    assign mb_mag = WIDTH'(abs_val(MAX_W'(b), sgn & b[WIDTH-1]));

    assign last = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ma_ext <= '0;
            acc    <= '0;
            mb     <= '0;
            cnt    <= '0;
            neg    <= 1'b0;
            s      <= '0;
        end else begin
            if (load) begin
                ma_ext <= {{WIDTH{1'b0}}, ma_mag};
                mb     <= mb_mag;
                neg    <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
                acc    <= '0;
                cnt    <= '0;
            end else if (step) begin
                if (mb[0]) begin
                    acc <= acc + ma_ext;
                end
                ma_ext <= ma_ext << 1;
                mb     <= mb >> 1;
                cnt    <= cnt + CW'(1);
            end
            if (finish) begin
                s <= neg ? -acc : acc;
            end
        end
    end

endmodule

// File: rtl/seq_array_mul.sv
// rtl/seq_array_mul.sv - iterative signed/unsigned multiplier with valid/ready handshakes
module seq_array_mul
    import seq_mul_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               sgn,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] s
);

    state_t state_q;
    state_t state_d;
    logic   out_valid_d;
    logic   load;
    logic   step;
    logic   finish;
    logic   last;

    assign in_ready = (state_q == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            out_valid <= 1'b0;
        end else begin
            state_q   <= state_d;
            out_valid <= out_valid_d;
        end
    end

    // DONE spends its first cycle registering the signed result, then waits for out_ready.
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid;
        load        = 1'b0;
        step        = 1'b0;
        finish      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    load    = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                step = 1'b1;
                if (last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (!out_valid) begin
                    finish      = 1'b1;
                    out_valid_d = 1'b1;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    seq_mul_dp #(.WIDTH(WIDTH)) u_dp (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (load),
        .step   (step),
        .finish (finish),
        .a      (a),
        .b      (b),
        .sgn    (sgn),
        .last   (last),
        .s      (s)
    );

endmodule

// File: tb/tb_seq_array_mul.sv
// tb/tb_seq_array_mul.sv - directed self-checking bench for seq_array_mul at WIDTH 8 and 4
module tb_seq_array_mul;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        in_valid8 = 1'b0, in_ready8, sgn8 = 1'b0, out_valid8, out_ready8 = 1'b1;
    logic [7:0]  a8 = '0, b8 = '0;
    logic [15:0] s8;

    logic        in_valid4 = 1'b0, in_ready4, sgn4 = 1'b0, out_valid4, out_ready4 = 1'b1;
    logic [3:0]  a4 = '0, b4 = '0;
    logic [7:0]  s4;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    seq_array_mul #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .sgn(sgn8), .out_valid(out_valid8), .out_ready(out_ready8), .s(s8)
    );

    seq_array_mul #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .sgn(sgn4), .out_valid(out_valid4), .out_ready(out_ready4), .s(s4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ref8(input logic [7:0] x, input logic [7:0] y, input logic sg);
        int px, py;
        px = sg ? int'($signed(x)) : int'(x);
        py = sg ? int'($signed(y)) : int'(y);
        return 16'(px * py);
    endfunction

    task automatic run8(input string tag, input logic [7:0] av, input logic [7:0] bv,
                        input logic sg, input logic [15:0] exp);
        int n;
        check({tag, ":rdy"}, 32'(in_ready8), 32'd1);
        a8 = av; b8 = bv; sgn8 = sg; in_valid8 = 1'b1; out_ready8 = 1'b1;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        n = 0;
        while (!out_valid8 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, ":lat"}, 32'(n), 32'd9);
        check({tag, ":s"}, 32'(s8), 32'(exp));
        @(posedge clk); #1;
        check({tag, ":pulse"}, 32'(out_valid8), 32'd0);
        check({tag, ":idle"}, 32'(in_ready8), 32'd1);
    endtask

    task automatic run4(input string tag, input logic [3:0] av, input logic [3:0] bv,
                        input logic sg, input logic [7:0] exp);
        int n;
        check({tag, ":rdy"}, 32'(in_ready4), 32'd1);
        a4 = av; b4 = bv; sgn4 = sg; in_valid4 = 1'b1; out_ready4 = 1'b1;
        @(posedge clk); #1;
        in_valid4 = 1'b0;
        n = 0;
        while (!out_valid4 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, ":lat"}, 32'(n), 32'd5);
        check({tag, ":s"}, 32'(s4), 32'(exp));
        @(posedge clk); #1;
        check({tag, ":pulse"}, 32'(out_valid4), 32'd0);
        check({tag, ":idle"}, 32'(in_ready4), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        logic [7:0] ra, rb;
        logic       rs;

        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready8), 32'd1);
        check("rst_out_valid", 32'(out_valid8), 32'd0);
        check("rst_s", 32'(s8), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        run4("w4_15x15", 4'd15, 4'd15, 1'b0, 8'hE1);
        run4("w4_m8xm8", 4'h8, 4'h8, 1'b1, 8'h40);
        run4("w4_m8x7", 4'h8, 4'h7, 1'b1, 8'hC8);
        run4("w4_3xm2", 4'h3, 4'hE, 1'b1, 8'hFA);

        run8("m128xm128", 8'h80, 8'h80, 1'b1, 16'h4000);
        run8("m3x7", 8'hFD, 8'h07, 1'b1, 16'hFFEB);
        run8("127xm1", 8'h7F, 8'hFF, 1'b1, 16'hFF81);
        run8("u_ffxff", 8'hFF, 8'hFF, 1'b0, 16'hFE01);
        run8("s_ffxff", 8'hFF, 8'hFF, 1'b1, 16'h0001);
        run8("u_128x2", 8'h80, 8'h02, 1'b0, 16'h0100);
        run8("m128x127", 8'h80, 8'h7F, 1'b1, 16'hC080);
        run8("zero_a", 8'h00, 8'hC8, 1'b0, 16'h0000);
        run8("zero_s", 8'h00, 8'hFB, 1'b1, 16'h0000);
        run8("200x3", 8'd200, 8'd3, 1'b0, 16'h0258);

        for (int i = 0; i < 24; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rs = 1'($urandom);
            run8("rand", ra, rb, rs, ref8(ra, rb, rs));
        end

        // Back-pressure: hold the result for 20 cycles while a second request is offered.
        out_ready8 = 1'b0;
        a8 = 8'd9; b8 = 8'd9; sgn8 = 1'b0; in_valid8 = 1'b1;
        @(posedge clk); #1;
        a8 = 8'd2; b8 = 8'd2;
        n = 0;
        while (!out_valid8 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("bp_lat", 32'(n), 32'd9);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            check("bp_valid", 32'(out_valid8), 32'd1);
            check("bp_s", 32'(s8), 32'h51);
            check("bp_in_ready", 32'(in_ready8), 32'd0);
        end
        in_valid8 = 1'b0;
        out_ready8 = 1'b1;
        @(posedge clk); #1;
        check("bp_consumed", 32'(out_valid8), 32'd0);
        check("bp_idle", 32'(in_ready8), 32'd1);
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            check("bp_no_dup", 32'(out_valid8), 32'd0);
        end
        check("bp_s_kept", 32'(s8), 32'h51);

        // Reset in the middle of an iteration sequence.
        a8 = 8'd200; b8 = 8'd3; sgn8 = 1'b0; in_valid8 = 1'b1;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("mid_busy", 32'(in_ready8), 32'd0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(out_valid8), 32'd0);
        check("mid_rst_s", 32'(s8), 32'd0);
        check("mid_rst_ready", 32'(in_ready8), 32'd1);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_ready", 32'(in_ready8), 32'd1);
        run8("post_rst_5x6", 8'd5, 8'd6, 1'b0, 16'd30);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
